// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 3;
    localparam int SB_DEPTH  = 3;

    // Scoreboard slot order: 0 is the youngest (ID/EX), SB_DEPTH-1 the oldest (MEM/WB)
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 is_load;
        logic                 is_halt;
    } sb_entry_t;

    function automatic sb_entry_t make_entry(
        input logic                 reg_w_en,
        input logic [REG_IDX_W-1:0] rd,
        input logic                 is_load,
        input logic                 is_halt
    );
        sb_entry_t e;
        e.valid   = reg_w_en;
        e.rd      = rd;
        e.is_load = is_load;
        e.is_halt = is_halt;
        return e;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard: a shift register of in-flight writers, one slot per
// stage after decode, advancing whenever ID/EX is enabled.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_advance,
    input  sb_entry_t                   i_id_entry,
    output sb_entry_t [SB_DEPTH-1:0]    o_sb
);

    sb_entry_t r_sb [SB_DEPTH];

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sb[gi] <= '0;
                    end else if (i_advance) begin
                        r_sb[gi] <= i_id_entry;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sb[gi] <= '0;
                    end else if (i_advance) begin
                        r_sb[gi] <= r_sb[gi-1];
                    end
                end
            end
            assign o_sb[gi] = r_sb[gi];
        end
    endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall, taken-branch flush, memory-wait
// freeze and halt drain. Define PIPE_FWD_EN when EX/MEM forwarding exists.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_id_valid,
    input  logic [REG_IDX_W-1:0]    i_id_rs,
    input  logic                    i_id_rs_used,
    input  logic [REG_IDX_W-1:0]    i_id_rt,
    input  logic                    i_id_rt_used,
    input  logic [REG_IDX_W-1:0]    i_id_rd,
    input  logic                    i_id_reg_w_en,
    input  logic                    i_id_read_mem,
    input  logic                    i_id_halt,
    input  logic                    i_ex_branch_taken,
    input  logic                    i_mem_busy,
    output logic                    o_pc_en,
    output logic                    o_if_id_en,
    output logic                    o_if_id_flush,
    output logic                    o_id_ex_en,
    output logic                    o_id_ex_bubble,
    output logic                    o_ex_mem_en,
    output logic                    o_mem_wb_en,
    output logic                    o_halted,
    output logic [STALL_CNT_W-1:0]  o_stall_cnt
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_branch_pend;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;

    sb_entry_t [SB_DEPTH-1:0] w_sb;
    sb_entry_t                w_id_entry;
    logic [SB_DEPTH-1:0]      w_rs_hit;
    logic [SB_DEPTH-1:0]      w_rt_hit;
    logic [SB_DEPTH-1:0]      w_unused_flags;
    logic                     w_hazard;
    logic                     w_branch;
    logic                     w_stall_inc;

    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en;
    logic w_id_ex_bubble, w_ex_mem_en, w_mem_wb_en, w_halted;

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_cmp
            logic w_checked;
`ifdef PIPE_FWD_EN
            // Forwarding covers everything except a load still in EX
            assign w_checked = (gi == SB_EX) && w_sb[gi].is_load;
`else
            assign w_checked = (gi != SB_WB) || (WB_BYPASS == 0);
`endif
            assign w_rs_hit[gi] = w_checked && w_sb[gi].valid && (w_sb[gi].rd == i_id_rs);
            assign w_rt_hit[gi] = w_checked && w_sb[gi].valid && (w_sb[gi].rd == i_id_rt);
            assign w_unused_flags[gi] = w_sb[gi].is_load ^ w_sb[gi].is_halt;
        end
    endgenerate

    assign w_hazard = i_id_valid && ((i_id_rs_used && (|w_rs_hit)) ||
                                     (i_id_rt_used && (|w_rt_hit)));

    // A branch seen while frozen is held until the pipeline can move again
    assign w_branch = i_ex_branch_taken || r_branch_pend;

    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_mem_wb_en    = 1'b1;
        w_halted       = 1'b0;
        w_stall_inc    = 1'b0;
        w_state_next   = r_state;
        unique case (r_state)
            RUN: begin
                if (i_mem_busy) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_mem_wb_en = 1'b0;
                end else if (w_branch) begin
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (w_hazard) begin
                    w_pc_en        = 1'b0;
                    w_if_id_en     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_stall_inc    = 1'b1;
                end else if (i_id_valid && i_id_halt) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_mem_busy) begin
                    w_pc_en     = 1'b0;
                    w_if_id_en  = 1'b0;
                    w_id_ex_en  = 1'b0;
                    w_ex_mem_en = 1'b0;
                    w_mem_wb_en = 1'b0;
                end else if (w_branch) begin
                    // The halt sat on a mispredicted path; resume normal fetch
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_state_next   = RUN;
                end else begin
                    // Everything younger than the halt is discarded, not executed
                    w_pc_en        = 1'b0;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    if (w_sb[SB_WB].is_halt) begin
                        w_state_next = HALTED;
                    end
                end
            end
            HALTED: begin
                w_pc_en     = 1'b0;
                w_if_id_en  = 1'b0;
                w_id_ex_en  = 1'b0;
                w_ex_mem_en = 1'b0;
                w_mem_wb_en = 1'b0;
                w_halted    = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign w_id_entry = (!i_id_valid || w_id_ex_bubble)
                      ? '0
                      : make_entry(i_id_reg_w_en, i_id_rd, i_id_read_mem, i_id_halt);

    pipe_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (w_id_ex_en),
        .i_id_entry (w_id_entry),
        .o_sb       (w_sb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_pend <= 1'b0;
        end else if (i_mem_busy) begin
            r_branch_pend <= r_branch_pend || i_ex_branch_taken;
        end else begin
            r_branch_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_pc_en        = w_pc_en;
    assign o_if_id_en     = w_if_id_en;
    assign o_if_id_flush  = w_if_id_flush;
    assign o_id_ex_en     = w_id_ex_en;
    assign o_id_ex_bubble = w_id_ex_bubble;
    assign o_ex_mem_en    = w_ex_mem_en;
    assign o_mem_wb_en    = w_mem_wb_en;
    assign o_halted       = w_halted;
    assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW stalls, flush priority, memory
// freeze with a pending branch, halt drain and asynchronous reset.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        i_id_valid;
    logic [2:0]  i_id_rs;
    logic        i_id_rs_used;
    logic [2:0]  i_id_rt;
    logic        i_id_rt_used;
    logic [2:0]  i_id_rd;
    logic        i_id_reg_w_en;
    logic        i_id_read_mem;
    logic        i_id_halt;
    logic        i_ex_branch_taken;
    logic        i_mem_busy;
    logic        o_pc_en;
    logic        o_if_id_en;
    logic        o_if_id_flush;
    logic        o_id_ex_en;
    logic        o_id_ex_bubble;
    logic        o_ex_mem_en;
    logic        o_mem_wb_en;
    logic        o_halted;
    logic [15:0] o_stall_cnt;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, halted}
    logic [7:0]  w_ctl;
    localparam logic [7:0] NORM   = 8'b1101_0110;
    localparam logic [7:0] STALL  = 8'b0001_1110;
    localparam logic [7:0] FLUSH  = 8'b1111_1110;
    localparam logic [7:0] FROZEN = 8'b0000_0000;
    localparam logic [7:0] DRAIN  = 8'b0111_1110;
    localparam logic [7:0] HALT   = 8'b0000_0001;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_stall = 0;

    pipe_hazard_ctrl #(
        .WB_BYPASS   (1),
        .STALL_CNT_W (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_id_valid        (i_id_valid),
        .i_id_rs           (i_id_rs),
        .i_id_rs_used      (i_id_rs_used),
        .i_id_rt           (i_id_rt),
        .i_id_rt_used      (i_id_rt_used),
        .i_id_rd           (i_id_rd),
        .i_id_reg_w_en     (i_id_reg_w_en),
        .i_id_read_mem     (i_id_read_mem),
        .i_id_halt         (i_id_halt),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_mem_busy        (i_mem_busy),
        .o_pc_en           (o_pc_en),
        .o_if_id_en        (o_if_id_en),
        .o_if_id_flush     (o_if_id_flush),
        .o_id_ex_en        (o_id_ex_en),
        .o_id_ex_bubble    (o_id_ex_bubble),
        .o_ex_mem_en       (o_ex_mem_en),
        .o_mem_wb_en       (o_mem_wb_en),
        .o_halted          (o_halted),
        .o_stall_cnt       (o_stall_cnt)
    );

    assign w_ctl = {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en,
                    o_id_ex_bubble, o_ex_mem_en, o_mem_wb_en, o_halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic rs_u,
                          input logic [2:0] rt, input logic rt_u, input logic [2:0] rd,
                          input logic wen, input logic ld, input logic hlt);
        i_id_valid    = v;
        i_id_rs       = rs;
        i_id_rs_used  = rs_u;
        i_id_rt       = rt;
        i_id_rt_used  = rt_u;
        i_id_rd       = rd;
        i_id_reg_w_en = wen;
        i_id_read_mem = ld;
        i_id_halt     = hlt;
    endtask

    initial begin
        rst = 1'b0;
        i_ex_branch_taken = 1'b0;
        i_mem_busy = 1'b0;
        set_id(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("reset_ctl", {24'd0, w_ctl}, {24'd0, NORM});
        chk("reset_stall_cnt", 32'(o_stall_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD R1 then an ADD reading R1
        tick(); set_id(1, 3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0); #1;
        chk("t1_producer", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd1, 1, 3'd3, 1, 3'd4, 1, 0, 0); #1;
`ifdef PIPE_FWD_EN
        chk("t1_fwd_no_stall", {24'd0, w_ctl}, {24'd0, NORM});
        exp_stall = 0;
`else
        chk("t1_stall_ex", {24'd0, w_ctl}, {24'd0, STALL});
        tick(); #1;
        chk("t1_stall_mem", {24'd0, w_ctl}, {24'd0, STALL});
        tick(); #1;
        chk("t1_wb_bypass", {24'd0, w_ctl}, {24'd0, NORM});
        exp_stall = 2;
`endif
        chk("t1_stall_cnt", 32'(o_stall_cnt), 32'(exp_stall));

        // LD R2 then an ADD reading R2 on rt
        tick(); set_id(1, 3'd5, 1, 3'd0, 0, 3'd2, 1, 1, 0); #1;
        chk("t2_load_issue", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd0, 1, 3'd2, 1, 3'd6, 1, 0, 0); #1;
        chk("t2_load_use", {24'd0, w_ctl}, {24'd0, STALL});
`ifdef PIPE_FWD_EN
        tick(); #1;
        chk("t2_fwd_resume", {24'd0, w_ctl}, {24'd0, NORM});
        exp_stall = 1;
`else
        tick(); #1;
        chk("t2_stall_mem", {24'd0, w_ctl}, {24'd0, STALL});
        tick(); #1;
        chk("t2_resume", {24'd0, w_ctl}, {24'd0, NORM});
        exp_stall = 4;
`endif
        chk("t2_stall_cnt", 32'(o_stall_cnt), 32'(exp_stall));

        // Invalid ID slot and unused source never stall
        tick(); set_id(0, 3'd6, 1, 3'd6, 1, 3'd0, 0, 0, 0); #1;
        chk("t3_invalid_id", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd6, 0, 3'd7, 1, 3'd3, 1, 1, 0); #1;
        chk("t3_rs_unused", {24'd0, w_ctl}, {24'd0, NORM});

        // Taken branch coincident with a load-use hazard on R3
        tick(); set_id(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 0); i_ex_branch_taken = 1'b1; #1;
        chk("t4_flush_over_hazard", {24'd0, w_ctl}, {24'd0, FLUSH});
        tick(); i_ex_branch_taken = 1'b0; set_id(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0); #1;
        chk("t4_after_flush", {24'd0, w_ctl}, {24'd0, NORM});
        chk("t4_stall_cnt", 32'(o_stall_cnt), 32'(exp_stall));

        // Memory wait with a branch in EX: frozen 3 cycles, flush on the 4th
        tick(); i_mem_busy = 1'b1; i_ex_branch_taken = 1'b1; #1;
        chk("t5_busy_1", {24'd0, w_ctl}, {24'd0, FROZEN});
        tick(); i_ex_branch_taken = 1'b0; #1;
        chk("t5_busy_2", {24'd0, w_ctl}, {24'd0, FROZEN});
        tick(); #1;
        chk("t5_busy_3", {24'd0, w_ctl}, {24'd0, FROZEN});
        tick(); i_mem_busy = 1'b0; #1;
        chk("t5_pending_flush", {24'd0, w_ctl}, {24'd0, FLUSH});
        tick(); #1;
        chk("t5_resume", {24'd0, w_ctl}, {24'd0, NORM});

        // HALT: drain until it reaches WB, then stop for good
        tick(); set_id(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0, 0); #1;
        chk("t6_pre_halt", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); #1;
        chk("t6_halt_in_id", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd5, 1, 3'd0, 0, 3'd3, 1, 0, 0); #1;
        chk("t6_drain_ex", {24'd0, w_ctl}, {24'd0, DRAIN});
        tick(); #1;
        chk("t6_drain_mem", {24'd0, w_ctl}, {24'd0, DRAIN});
        tick(); #1;
        chk("t6_drain_wb", {24'd0, w_ctl}, {24'd0, DRAIN});
        tick(); #1;
        chk("t6_halted", {24'd0, w_ctl}, {24'd0, HALT});
        tick(); i_ex_branch_taken = 1'b1; #1;
        chk("t6_halted_sticky", {24'd0, w_ctl}, {24'd0, HALT});
        i_ex_branch_taken = 1'b0;
        rst = 1'b1; #1;
        chk("t6_reset_from_halt", {24'd0, w_ctl}, {24'd0, NORM});
        chk("t6_reset_stall_cnt", 32'(o_stall_cnt), 32'd0);
        tick(); rst = 1'b0; set_id(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);

        // Asynchronous reset in the middle of a drain
        tick(); set_id(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 0); #1;
        chk("t7_producer", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); #1;
        chk("t7_halt_in_id", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); set_id(1, 3'd5, 1, 3'd0, 0, 3'd3, 1, 0, 0); #1;
        chk("t7_drain", {24'd0, w_ctl}, {24'd0, DRAIN});
        rst = 1'b1; #1;
        chk("t7_async_reset", {24'd0, w_ctl}, {24'd0, NORM});
        tick(); rst = 1'b0; #1;
        chk("t7_sb_cleared", {24'd0, w_ctl}, {24'd0, NORM});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
